// File: rtl/croc_uart_mon_pkg.sv
// Shared definitions for the UART receive monitor.
//   uart_state_e : receiver FSM states
//   CRC8_POLY    : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   DATA_BITS    : data bits per UART frame
//   crc8_update  : one-byte CRC-8 step, MSB first, no reflection
package croc_uart_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } uart_state_e;

  localparam logic [7:0]  CRC8_POLY = 8'h07;
  localparam int unsigned DATA_BITS = 8;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// First-word-fall-through FIFO used to buffer received bytes.
// Ports:
//   soc_clk, rst_n : clock, asynchronous active-low reset
//   clear_i        : synchronous flush; has priority over push and pop
//   push_i, data_i : write request and data; dropped when full unless popping
//   pop_i          : consume head entry; ignored when empty
//   data_o         : head entry (zero when empty)
//   full_o, empty_o: occupancy status
module uart_mon_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic             soc_clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot being written, so full+pop still accepts.
  assign do_push = push_i && (!full_o || pop_i);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge soc_clk) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: samples an asynchronous 8N1 line, buffers good bytes
// in a FIFO and keeps frame statistics.
// Optional feature: define CROC_UART_MON_CRC_EN to enable the running CRC-8
// of accepted bytes on crc_o; otherwise crc_o is tied to zero.
// Ports:
//   soc_clk, rst_n : clock, asynchronous active-low reset
//   uart_i         : serial line, asynchronous, idle high
//   clear_i        : flush FIFO, zero count, sticky flags and CRC (FSM untouched)
//   pop_i          : consume FIFO head
//   data_o/valid_o : FIFO head byte / FIFO not empty
//   count_o        : good frames received, saturating
//   frame_err_o    : sticky, stop bit sampled low
//   overflow_o     : sticky, byte dropped on full FIFO
//   busy_o         : receiver not idle
//   crc_o          : running CRC-8 of accepted bytes
module uart_rx_monitor
  import croc_uart_mon_pkg::*;
#(
  parameter int unsigned BaudDiv   = 174,
  parameter int unsigned FifoDepth = 16
) (
  input  logic        soc_clk,
  input  logic        rst_n,
  input  logic        uart_i,
  input  logic        clear_i,
  input  logic        pop_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic [15:0] count_o,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic [7:0]  crc_o
);

  localparam logic [15:0] FullDiv = 16'(BaudDiv);
  localparam logic [15:0] HalfDiv = 16'(BaudDiv / 2);

  // Two-flop synchronizer, reset to the idle-high line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  uart_state_e          state_q;
  logic [15:0]          timer_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 push_q;
  logic                 stop_bad_q;
  logic                 tick;

  // Timer counts down from its load value; expiry is the cycle it reads 1,
  // i.e. exactly N cycles after the load.
  assign tick = (timer_q == 16'd1);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      stop_bad_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            timer_q <= HalfDiv;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              timer_q   <= FullDiv;
              bit_idx_q <= '0;
              state_q   <= StData;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StData: begin
          if (tick) begin
            shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            timer_q   <= FullDiv;
            if (bit_idx_q == 3'(DATA_BITS - 1)) state_q <= StStop;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StStop: begin
          if (tick) begin
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              stop_bad_q <= 1'b1;
              state_q    <= StWaitHigh;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StWaitHigh: begin
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);

  logic fifo_full, fifo_empty;

  uart_mon_fifo #(
    .Depth (FifoDepth),
    .Width (DATA_BITS)
  ) u_fifo (
    .soc_clk (soc_clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (pop_i),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o = !fifo_empty;

  logic        accept;
  logic [15:0] count_q;
  logic        frame_err_q, overflow_q;

  // Mirrors the FIFO's acceptance rule so CRC only covers stored bytes.
  assign accept = push_q && (!fifo_full || pop_i);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clear_i) begin
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      // Good frames count even when the FIFO drops them.
      if (push_q && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      if (stop_bad_q) frame_err_q <= 1'b1;
      if (push_q && fifo_full && !pop_i) overflow_q <= 1'b1;
    end
  end

  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

`ifdef CROC_UART_MON_CRC_EN
  logic [7:0] crc_q;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (clear_i) begin
      crc_q <= '0;
    end else if (accept) begin
      crc_q <= crc8_update(crc_q, shift_q);
    end
  end

  assign crc_o = crc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign crc_o         = '0;
`endif

endmodule
